// File: rtl/wb_sram_bridge.sv
// Wishbone classic slave driving an external asynchronous SRAM narrower than the bus.
// Each access becomes one SETUP/STROBE pair per beat that has at least one selected byte lane.
module wb_sram_bridge #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned ADDR_BITS   = 17,
   parameter int unsigned SRAM_DW     = 16,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                                        clk_i,
   input  logic                                        rst_i,
   input  logic                                        cyc_i,
   input  logic                                        stb_i,
   input  logic                                        we_i,
   input  logic [ADDR_BITS-3:0]                        adr_i,
   input  logic [XLEN/8-1:0]                           sel_i,
   input  logic [XLEN-1:0]                             slave_dat_i,
   output logic [XLEN-1:0]                             slave_dat_o,
   output logic                                        ack_o,
   output logic                                        err_o,
   output logic [ADDR_BITS-$clog2(SRAM_DW/8)-1:0]      sram_addr,
   input  logic [SRAM_DW-1:0]                          sram_dq_i,
   output logic [SRAM_DW-1:0]                          sram_dq_o,
   output logic                                        sram_dq_oe,
   output logic                                        sram_ce_n,
   output logic                                        sram_oe_n,
   output logic                                        sram_we_n,
   output logic [SRAM_DW/8-1:0]                        sram_be_n
);

   localparam int unsigned B      = SRAM_DW / 8;
   localparam int unsigned SB     = XLEN / 8;
   localparam int unsigned NBEATS = XLEN / SRAM_DW;
   localparam int unsigned BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int unsigned SAW    = ADDR_BITS - $clog2(B);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StSetup   = 3'd1;
   localparam logic [2:0] StStrobe  = 3'd2;
   localparam logic [2:0] StAck     = 3'd3;
   localparam logic [2:0] StRecover = 3'd4;

   function automatic logic [NBEATS-1:0] beat_mask(input logic [SB-1:0] s);
      beat_mask = '0;
      for (int unsigned k = 0; k < NBEATS; k++) beat_mask[k] = |s[k*B +: B];
   endfunction

   function automatic logic [BW-1:0] first_beat(input logic [NBEATS-1:0] m);
      first_beat = '0;
      for (int k = int'(NBEATS) - 1; k >= 0; k--) if (m[k]) first_beat = BW'(k);
   endfunction

   logic [2:0]           state_q, state_d;
   logic [2:0]           ws_cnt_q, ws_cnt_d;
   logic [BW-1:0]        beat_q, beat_d;
   logic [NBEATS-1:0]    rem_q, rem_d;
   logic [ADDR_BITS-3:0] adr_q, adr_d;
   logic [SB-1:0]        sel_q, sel_d;
   logic                 we_q, we_d;
   logic [XLEN-1:0]      wdat_q, wdat_d;
   logic [XLEN-1:0]      dat_q, dat_d;
   logic                 ack_q, ack_d;
   logic                 err_q, err_d;
   logic [SAW-1:0]       addr_q, addr_d;
   logic [SRAM_DW-1:0]   dq_o_q, dq_o_d;
   logic                 dq_oe_q, dq_oe_d;
   logic                 ce_n_q, ce_n_d;
   logic                 oe_n_q, oe_n_d;
   logic                 we_n_q, we_n_d;
   logic [B-1:0]         be_n_q, be_n_d;

   logic                 req, abort, go_setup;
   logic [BW-1:0]        setup_beat;
   logic [NBEATS-1:0]    rem_nx;
   logic [ADDR_BITS-3:0] src_adr;
   logic [SB-1:0]        src_sel;
   logic                 src_we;
   logic [XLEN-1:0]      src_wdat;

   assign req   = cyc_i & stb_i & ~ack_q & ~err_q;
   assign abort = ~(cyc_i & stb_i);

   always_comb begin
      state_d    = state_q;
      ws_cnt_d   = ws_cnt_q;
      beat_d     = beat_q;
      rem_d      = rem_q;
      adr_d      = adr_q;
      sel_d      = sel_q;
      we_d       = we_q;
      wdat_d     = wdat_q;
      dat_d      = dat_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      addr_d     = addr_q;
      dq_o_d     = dq_o_q;
      dq_oe_d    = dq_oe_q;
      ce_n_d     = ce_n_q;
      oe_n_d     = oe_n_q;
      we_n_d     = we_n_q;
      be_n_d     = be_n_q;
      go_setup   = 1'b0;
      setup_beat = '0;
      rem_nx     = rem_q;
      src_adr    = adr_q;
      src_sel    = sel_q;
      src_we     = we_q;
      src_wdat   = wdat_q;

      unique case (state_q)
         StIdle: begin
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            we_n_d  = 1'b1;
            be_n_d  = '1;
            dq_oe_d = 1'b0;
            if (req) begin
               adr_d  = adr_i;
               sel_d  = sel_i;
               we_d   = we_i;
               wdat_d = slave_dat_i;
               if (sel_i == '0) begin
                  err_d = 1'b1;
               end else begin
                  src_adr    = adr_i;
                  src_sel    = sel_i;
                  src_we     = we_i;
                  src_wdat   = slave_dat_i;
                  rem_d      = beat_mask(sel_i);
                  setup_beat = first_beat(beat_mask(sel_i));
                  go_setup   = 1'b1;
                  state_d    = StSetup;
                  if (!we_i) dat_d = '0;
               end
            end
         end
         StSetup: begin
            if (abort) begin
               state_d = StRecover;
               ce_n_d  = 1'b1;
            end else begin
               state_d  = StStrobe;
               ws_cnt_d = '0;
               if (we_q) we_n_d = 1'b0;
               else      oe_n_d = 1'b0;
            end
         end
         StStrobe: begin
            if (abort) begin
               // Address and data stay put so the SRAM sees a clean strobe release.
               state_d = StRecover;
               ce_n_d  = 1'b1;
               oe_n_d  = 1'b1;
               we_n_d  = 1'b1;
            end else if (ws_cnt_q != 3'(WAIT_STATES)) begin
               ws_cnt_d = ws_cnt_q + 3'd1;
            end else begin
               if (!we_q) begin
                  for (int unsigned l = 0; l < B; l++) begin
                     if (sel_q[int'(beat_q)*B + l]) begin
                        dat_d[int'(beat_q)*SRAM_DW + l*8 +: 8] = sram_dq_i[l*8 +: 8];
                     end
                  end
               end
               rem_nx[beat_q] = 1'b0;
               rem_d          = rem_nx;
               if (rem_nx != '0) begin
                  setup_beat = first_beat(rem_nx);
                  go_setup   = 1'b1;
                  state_d    = StSetup;
               end else begin
                  state_d = StAck;
                  ack_d   = 1'b1;
                  ce_n_d  = 1'b1;
                  oe_n_d  = 1'b1;
                  we_n_d  = 1'b1;
                  be_n_d  = '1;
                  dq_oe_d = 1'b0;
               end
            end
         end
         StAck: begin
            state_d = StIdle;
         end
         StRecover: begin
            state_d = StIdle;
            be_n_d  = '1;
            dq_oe_d = 1'b0;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (go_setup) begin
         beat_d  = setup_beat;
         ce_n_d  = 1'b0;
         oe_n_d  = 1'b1;
         we_n_d  = 1'b1;
         addr_d  = SAW'(src_adr) * SAW'(NBEATS) + SAW'(setup_beat);
         be_n_d  = ~src_sel[int'(setup_beat)*B +: B];
         dq_oe_d = src_we;
         if (src_we) dq_o_d = src_wdat[int'(setup_beat)*SRAM_DW +: SRAM_DW];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         ws_cnt_q <= '0;
         beat_q   <= '0;
         rem_q    <= '0;
         adr_q    <= '0;
         sel_q    <= '0;
         we_q     <= 1'b0;
         wdat_q   <= '0;
         dat_q    <= '0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         addr_q   <= '0;
         dq_o_q   <= '0;
         dq_oe_q  <= 1'b0;
         ce_n_q   <= 1'b1;
         oe_n_q   <= 1'b1;
         we_n_q   <= 1'b1;
         be_n_q   <= '1;
      end else begin
         state_q  <= state_d;
         ws_cnt_q <= ws_cnt_d;
         beat_q   <= beat_d;
         rem_q    <= rem_d;
         adr_q    <= adr_d;
         sel_q    <= sel_d;
         we_q     <= we_d;
         wdat_q   <= wdat_d;
         dat_q    <= dat_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         addr_q   <= addr_d;
         dq_o_q   <= dq_o_d;
         dq_oe_q  <= dq_oe_d;
         ce_n_q   <= ce_n_d;
         oe_n_q   <= oe_n_d;
         we_n_q   <= we_n_d;
         be_n_q   <= be_n_d;
      end
   end

   assign slave_dat_o = dat_q;
   assign ack_o       = ack_q;
   assign err_o       = err_q;
   assign sram_addr   = addr_q;
   assign sram_dq_o   = dq_o_q;
   assign sram_dq_oe  = dq_oe_q;
   assign sram_ce_n   = ce_n_q;
   assign sram_oe_n   = oe_n_q;
   assign sram_we_n   = we_n_q;
   assign sram_be_n   = be_n_q;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Bench for wb_sram_bridge: two instances (0 and 3 wait states) against a byte-array reference
// memory and a pin-level asynchronous SRAM model.
module tb_wb_sram_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, use3 = 1'b0;
   logic [14:0] adr = '0;
   logic [3:0]  sel = '0;
   logic [31:0] wdat = '0;

   logic [31:0] dat0, dat3;
   logic        ack0, err0, ack3, err3;
   logic [15:0] sram_addr, sram_addr3, sram_dq_i, sram_dq_o, sram_dq_i3, sram_dq_o3;
   logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
   logic        sram_dq_oe3, sram_ce_n3, sram_oe_n3, sram_we_n3;
   logic [1:0]  sram_be_n, sram_be_n3;

   logic        ack_m, err_m;
   logic [31:0] dat_m;
   assign ack_m = use3 ? ack3 : ack0;
   assign err_m = use3 ? err3 : err0;
   assign dat_m = use3 ? dat3 : dat0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wb_sram_bridge #(.XLEN(32), .ADDR_BITS(17), .SRAM_DW(16), .WAIT_STATES(0)) dut (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc & ~use3), .stb_i(stb), .we_i(we), .adr_i(adr),
      .sel_i(sel), .slave_dat_i(wdat), .slave_dat_o(dat0), .ack_o(ack0), .err_o(err0),
      .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
      .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
   );

   wb_sram_bridge #(.XLEN(32), .ADDR_BITS(17), .SRAM_DW(16), .WAIT_STATES(3)) dut3 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc & use3), .stb_i(stb), .we_i(we), .adr_i(adr),
      .sel_i(sel), .slave_dat_i(wdat), .slave_dat_o(dat3), .ack_o(ack3), .err_o(err3),
      .sram_addr(sram_addr3), .sram_dq_i(sram_dq_i3), .sram_dq_o(sram_dq_o3),
      .sram_dq_oe(sram_dq_oe3), .sram_ce_n(sram_ce_n3), .sram_oe_n(sram_oe_n3),
      .sram_we_n(sram_we_n3), .sram_be_n(sram_be_n3)
   );

   // Pin-level SRAM model; disabled lanes return junk so stray captures show up.
   logic [15:0] sram_mem [0:65535];
   assign sram_dq_i[7:0]  = (!sram_ce_n && !sram_oe_n && !sram_be_n[0]) ?
                            sram_mem[sram_addr][7:0] : 8'hC3;
   assign sram_dq_i[15:8] = (!sram_ce_n && !sram_oe_n && !sram_be_n[1]) ?
                            sram_mem[sram_addr][15:8] : 8'hC3;
   assign sram_dq_i3      = sram_addr3 ^ 16'h5A5A;

   int          ce_low_cnt = 0, ack_cnt = 0, err_cnt = 0, prot_bad = 0;
   int          oe_run = 0, oe_run3 = 0;
   int          oe_runs [$];
   int          oe_runs3 [$];
   logic [33:0] wq [$];  // {addr, be_n, dq}

   always @(negedge clk) begin
      if (!sram_ce_n) ce_low_cnt++;
      if (ack0) ack_cnt++;
      if (err0) err_cnt++;
      if (!sram_ce_n && !sram_we_n) begin
         if (!sram_dq_oe) prot_bad++;
         for (int l = 0; l < 2; l++)
            if (!sram_be_n[l]) sram_mem[sram_addr][l*8 +: 8] = sram_dq_o[l*8 +: 8];
         wq.push_back({sram_addr, sram_be_n, sram_dq_o});
      end
      if (!sram_oe_n) oe_run++;
      else if (oe_run != 0) begin oe_runs.push_back(oe_run); oe_run = 0; end
      if (!sram_oe_n3) oe_run3++;
      else if (oe_run3 != 0) begin oe_runs3.push_back(oe_run3); oe_run3 = 0; end
   end

   // Reference: byte-addressed memory, byte b of word a lives at a*4+b.
   logic [7:0] ref_b [0:255];

   function automatic void ref_write(input logic [14:0] a, input logic [3:0] s,
                                     input logic [31:0] d);
      for (int b = 0; b < 4; b++) if (s[b]) ref_b[int'(a)*4 + b] = d[b*8 +: 8];
   endfunction

   function automatic logic [31:0] ref_read(input logic [14:0] a, input logic [3:0] s);
      logic [31:0] r = '0;
      for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = ref_b[int'(a)*4 + b];
      return r;
   endfunction

   function automatic int exp_lat(input logic [3:0] s, input int ws);
      int n = 0;
      if (s[1:0] != 2'b00) n++;
      if (s[3:2] != 2'b00) n++;
      return n * (ws + 2) + 1;
   endfunction

   task automatic xfer(input logic w, input logic [14:0] a, input logic [3:0] s,
                       input logic [31:0] d, output logic [31:0] rd, output int lat,
                       output logic got_err);
      logic done = 1'b0;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
      lat = 0;
      while (!done && lat < 200) begin
         @(posedge clk); #1;
         lat++;
         done = ack_m | err_m;
      end
      got_err = err_m;
      rd      = dat_m;
      if (!done) lat = -1;
   endtask

   task automatic idle(input int n);
      cyc = 1'b0; stb = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({ack0, err0, dat0} !== 34'h0) begin
         bad++; $display("FAIL reset_wb: got %b/%b/%h want 0/0/0", ack0, err0, dat0);
      end
      total++;
      if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe} !== 6'b111110) begin
         bad++;
         $display("FAIL reset_pins: got ce%b oe%b we%b be%b dqoe%b want 1 1 1 11 0",
                  sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe);
      end
      rst = 1'b0;
      idle(1);
   endtask

   task automatic test_word_write;
      logic [31:0] rd; int lat; logic e; int w0;
      w0 = wq.size();
      xfer(1'b1, 15'h10, 4'hF, 32'hDEADBEEF, rd, lat, e);
      ref_write(15'h10, 4'hF, 32'hDEADBEEF);
      idle(1);
      total++;
      if (lat !== 5 || e) begin bad++; $display("FAIL word_write_lat: got %0d err%b want 5", lat, e); end
      total++;
      if (wq.size() - w0 !== 2) begin
         bad++; $display("FAIL word_write_beats: got %0d want 2", wq.size() - w0);
      end else begin
         total++;
         if (wq[w0] !== {16'h0020, 2'b00, 16'hBEEF} || wq[w0+1] !== {16'h0021, 2'b00, 16'hDEAD}) begin
            bad++; $display("FAIL word_write_pins: got %h %h want 0020_0_beef 0021_0_dead",
                            wq[w0], wq[w0+1]);
         end
      end
   endtask

   task automatic test_half_read;
      logic [31:0] rd; int lat; logic e; int r0;
      xfer(1'b1, 15'h10, 4'b1100, 32'h12340000, rd, lat, e);
      ref_write(15'h10, 4'b1100, 32'h12340000);
      idle(1);
      r0 = oe_runs.size();
      xfer(1'b0, 15'h10, 4'b1100, 32'h0, rd, lat, e);
      idle(1);
      total++;
      if (lat !== 3 || e) begin bad++; $display("FAIL half_read_lat: got %0d want 3", lat); end
      total++;
      if (rd !== 32'h12340000) begin bad++; $display("FAIL half_read_data: got %h want 12340000", rd); end
      total++;
      if (oe_runs.size() - r0 !== 1) begin
         bad++; $display("FAIL half_read_beats: got %0d want 1", oe_runs.size() - r0);
      end
   endtask

   task automatic test_byte_write;
      logic [31:0] rd; int lat; logic e; int w0;
      w0 = wq.size();
      xfer(1'b1, 15'h10, 4'b0100, 32'h00AB0000, rd, lat, e);
      ref_write(15'h10, 4'b0100, 32'h00AB0000);
      idle(1);
      total++;
      if (wq.size() - w0 !== 1 || wq[w0][33:16] !== {16'h0021, 2'b10} || wq[w0][7:0] !== 8'hAB) begin
         bad++; $display("FAIL byte_write_pins: got n=%0d %h want 1 0021_2_xxab", wq.size() - w0,
                         wq[w0]);
      end
      xfer(1'b0, 15'h10, 4'b1100, 32'h0, rd, lat, e);
      idle(1);
      total++;
      if (rd !== 32'h12AB0000) begin bad++; $display("FAIL byte_write_readback: got %h want 12ab0000", rd); end
   endtask

   task automatic test_err;
      logic [31:0] rd; int lat; logic e; int c0, a0;
      c0 = ce_low_cnt; a0 = ack_cnt;
      xfer(1'b1, 15'h3, 4'h0, 32'h11111111, rd, lat, e);
      idle(3);
      total++;
      if (lat !== 1 || !e) begin bad++; $display("FAIL err_pulse: got lat %0d err%b want 1 1", lat, e); end
      total++;
      if (ce_low_cnt - c0 !== 0 || ack_cnt - a0 !== 0) begin
         bad++; $display("FAIL err_no_sram: got ce_low %0d acks %0d want 0 0",
                         ce_low_cnt - c0, ack_cnt - a0);
      end
   endtask

   task automatic test_abort;
      int a0, e0;
      a0 = ack_cnt; e0 = err_cnt;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 15'h10; sel = 4'hF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++;
      if (sram_oe_n !== 1'b0) begin bad++; $display("FAIL abort_in_strobe: got oe_n %b want 0", sram_oe_n); end
      cyc = 1'b0;
      @(posedge clk); #1;
      total++;
      if (sram_oe_n !== 1'b1 || sram_we_n !== 1'b1 || sram_addr !== 16'h0020) begin
         bad++; $display("FAIL abort_recover: got oe_n %b we_n %b addr %h want 1 1 0020",
                         sram_oe_n, sram_we_n, sram_addr);
      end
      idle(4);
      total++;
      if (ack_cnt - a0 !== 0 || err_cnt - e0 !== 0) begin
         bad++; $display("FAIL abort_no_ack: got acks %0d errs %0d want 0 0", ack_cnt - a0, err_cnt - e0);
      end
   endtask

   task automatic test_reset_mid_write;
      logic [31:0] rd; int lat; logic e;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 15'h20; sel = 4'b1100; wdat = 32'hCAFE0000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
      total++;
      if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || ack0 !== 1'b0) begin
         bad++; $display("FAIL reset_mid_write: got we_n %b dq_oe %b ack %b want 1 0 0",
                         sram_we_n, sram_dq_oe, ack0);
      end
      rst = 1'b0;
      ref_write(15'h20, 4'b1100, 32'hCAFE0000);
      idle(1);
      xfer(1'b0, 15'h20, 4'b1100, 32'h0, rd, lat, e);
      idle(1);
      total++;
      if (lat !== 3 || rd !== 32'hCAFE0000) begin
         bad++; $display("FAIL after_reset_read: got lat %0d data %h want 3 cafe0000", lat, rd);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] rd, d; int lat; logic e;
      d = $urandom;
      xfer(1'b1, 15'h3, 4'hF, d, rd, lat, e);
      ref_write(15'h3, 4'hF, d);
      xfer(1'b0, 15'h3, 4'hF, 32'h0, rd, lat, e);
      idle(1);
      total++;
      if (lat !== 6 || rd !== d) begin
         bad++; $display("FAIL back_to_back: got lat %0d data %h want 6 %h", lat, rd, d);
      end
   endtask

   task automatic test_wait_states;
      logic [31:0] rd; int lat; logic e; int r0;
      use3 = 1'b1;
      r0 = oe_runs3.size();
      xfer(1'b0, 15'h10, 4'hF, 32'h0, rd, lat, e);
      idle(2);
      use3 = 1'b0;
      total++;
      if (lat !== exp_lat(4'hF, 3) || rd !== 32'h5A7B5A7A) begin
         bad++; $display("FAIL ws3_read: got lat %0d data %h want 11 5a7b5a7a", lat, rd);
      end
      total++;
      if (oe_runs3.size() - r0 !== 2 || oe_runs3[r0] !== 4 || oe_runs3[r0+1] !== 4) begin
         bad++; $display("FAIL ws3_oe_width: got %0d runs want 2 of 4", oe_runs3.size() - r0);
      end
   endtask

   task automatic test_random;
      logic [31:0] rd, d; int lat; logic e;
      logic [14:0] a; logic [3:0] s; logic w;
      for (int i = 0; i < 16; i++) begin
         d = $urandom;
         xfer(1'b1, 15'(i), 4'hF, d, rd, lat, e);
         ref_write(15'(i), 4'hF, d);
         idle(1);
         total++;
         if (lat !== 5 || e) begin bad++; $display("FAIL rand_fill_lat: got %0d want 5", lat); end
      end
      for (int i = 0; i < 60; i++) begin
         a = 15'($urandom_range(0, 15));
         s = 4'($urandom_range(0, 15));
         w = 1'($urandom_range(0, 1));
         d = $urandom;
         xfer(w, a, s, d, rd, lat, e);
         idle($urandom_range(1, 2));
         total++;
         if (s == 4'h0) begin
            if (lat !== 1 || !e) begin bad++; $display("FAIL rand_err: got lat %0d err%b want 1 1", lat, e); end
         end else if (lat !== exp_lat(s, 0) || e) begin
            bad++; $display("FAIL rand_lat: sel %b got %0d want %0d", s, lat, exp_lat(s, 0));
         end
         if (s != 4'h0) begin
            if (w) ref_write(a, s, d);
            else begin
               total++;
               if (rd !== ref_read(a, s)) begin
                  bad++; $display("FAIL rand_read: adr %h sel %b got %h want %h", a, s, rd, ref_read(a, s));
               end
            end
         end
      end
      total++;
      if (prot_bad !== 0) begin bad++; $display("FAIL write_without_dq_oe: got %0d want 0", prot_bad); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_b[i] = 8'h00;
      test_reset();
      test_word_write();
      test_half_read();
      test_byte_write();
      test_err();
      test_abort();
      test_reset_mid_write();
      test_back_to_back();
      test_wait_states();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
